// File: rtl/csa_operand_sequencer.sv
// Byte-serial operand loader and result capture for the 32-bit carry-select adder.
// Optional signed-overflow result bit is enabled by defining CSA_SEQ_OVERFLOW_EN.
module csa_operand_sequencer #(
    parameter int BYTE_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_cin,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic              add_cin,
    input  logic [31:0]       add_sum,
    input  logic              add_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_sum,
    output logic              res_cout,
`ifdef CSA_SEQ_OVERFLOW_EN
    output logic              res_ovf,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, HOLD} state_t;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [3:0]  r_settle_cnt;
    logic [31:0] r_add_a;
    logic [31:0] r_add_b;
    logic        r_add_cin;
    logic [31:0] r_res_sum;
    logic        r_res_cout;
    logic        r_res_valid;
    logic        w_in_ready;
    logic        w_xfer;
    logic [4:0]  w_bit_base;

    assign w_in_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_bit_base = {r_byte_cnt, 3'b000};

`ifdef CSA_SEQ_OVERFLOW_EN
    logic r_res_ovf;
    logic w_ovf;
    // Same-sign operands producing an opposite-sign sum
    assign w_ovf = (r_add_a[31] == r_add_b[31]) && (add_sum[31] != r_add_a[31]);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_res_ovf <= 1'b0;
        else if (r_state == SETTLE && r_settle_cnt == 4'd0)
            r_res_ovf <= w_ovf;
    end

    assign res_ovf = r_res_ovf;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= LOAD_A;
            r_byte_cnt   <= 2'd0;
            r_settle_cnt <= 4'd0;
            r_add_a      <= 32'd0;
            r_add_b      <= 32'd0;
            r_add_cin    <= 1'b0;
            r_res_sum    <= 32'd0;
            r_res_cout   <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_xfer) begin
                        r_add_a[w_bit_base +: 8] <= in_data[7:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3)
                            r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_xfer) begin
                        r_add_b[w_bit_base +: 8] <= in_data[7:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_add_cin    <= in_cin;
                            r_settle_cnt <= 4'(SETTLE_CYCLES - 1);
                            r_state      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_res_sum   <= add_sum;
                        r_res_cout  <= add_cout;
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= LOAD_A;
                    end
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign busy      = !((r_state == LOAD_A) && (r_byte_cnt == 2'd0));

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// Testbench for csa_operand_sequencer: table-driven transactions checked through a
// result scoreboard, plus hand-written latency, backpressure and reset sequences.
module tb_csa_operand_sequencer;

    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_cin = 1'b0;
    logic        res_ready = 1'b1;
    logic        in_ready, add_cin, add_cout, res_valid, res_cout, busy;
    logic [31:0] add_a, add_b, add_sum, res_sum;
`ifdef CSA_SEQ_OVERFLOW_EN
    logic        res_ovf;
`endif

    csa_operand_sequencer #(.BYTE_W(8), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout),
`ifdef CSA_SEQ_OVERFLOW_EN
        .res_ovf(res_ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        gap;
        logic [33:0] exp;   // {ovf, cout, sum}
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        #2;
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: actual res_sum 0x%0h required no result", res_sum);
            end else begin
                e = sb_q.pop_front();
                chk("sb_res_sum", 64'(res_sum), 64'(e[31:0]));
                chk("sb_res_cout", 64'(res_cout), 64'(e[32]));
`ifdef CSA_SEQ_OVERFLOW_EN
                chk("sb_res_ovf", 64'(res_ovf), 64'(e[33]));
`endif
            end
        end
    end

    // Called and returns on a falling edge; the byte is consumed on the rising edge in between.
    task automatic send_byte(input logic [7:0] d, input logic c);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual in_ready 0 required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_cin   = 1'b0;
    endtask

    task automatic send_txn(input logic [31:0] a, input logic [31:0] b, input logic c,
                            input logic gap, input logic push, input logic [33:0] exp);
        logic [31:0] ta;
        logic [31:0] tb;
        ta = a;
        tb = b;
        for (int i = 0; i < 4; i++) begin
            if (gap) @(negedge clk);
            send_byte(ta[8*i +: 8], 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            if (gap) @(negedge clk);
            if (i == 3 && push) sb_q.push_back(exp);
            send_byte(tb[8*i +: 8], (i == 3) ? c : 1'b0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        tbl[0] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000}};
        tbl[1] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, {1'b0, 1'b1, 32'h00000000}};
        tbl[2] = '{32'hDEADBEEF, 32'h01234567, 1'b1, 1'b1, {1'b0, 1'b0, 32'hDFD10457}};
        tbl[3] = '{32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, {1'b0, 1'b0, 32'hDFD10457}};
        tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b0, 32'h80000000}};
        tbl[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000}};
        tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h00000000}};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        chk("rst_add_b", 64'(add_b), 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);
        chk("rst_res_sum", 64'(res_sum), 64'd0);
        chk("rst_res_cout", 64'(res_cout), 64'd0);
`ifdef CSA_SEQ_OVERFLOW_EN
        chk("rst_res_ovf", 64'(res_ovf), 64'd0);
`endif

        // Byte order: A bytes arrive 78,56,34,12
        send_txn(32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h12345678});
        chk("order_add_a", 64'(add_a), 64'h12345678);
        chk("order_add_b", 64'(add_b), 64'h0);
        chk("order_add_cin", 64'(add_cin), 64'd0);
        chk("order_in_ready", 64'(in_ready), 64'd0);
        chk("order_busy", 64'(busy), 64'd1);
        wait_drain();

        for (int i = 0; i < 7; i++) begin
            send_txn(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].gap, 1'b1, tbl[i].exp);
            chk("vec_add_b", 64'(add_b), 64'(tbl[i].b));
            wait_drain();
            chk("vec_idle", 64'(busy), 64'd0);
        end

        // Latency, backpressure, and in_valid ignored while not ready
        res_ready = 1'b0;
        send_txn(32'h11111111, 32'h22222222, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 32'h33333334});
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 1; i <= SC; i++) begin
            @(negedge clk);
            chk("lat_res_valid", 64'(res_valid), (i == SC) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_res_sum", 64'(res_sum), 64'h33333334);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_release_valid", 64'(res_valid), 64'd0);
        chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset part-way through B, then a fresh transaction
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEE, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_add_a", 64'(add_a), 64'd0);
        chk("midrst_add_b", 64'(add_b), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        send_txn(32'd5, 32'd7, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000000C});
        wait_drain();

        // Reset while a result is held drops res_valid without handshake
        res_ready = 1'b0;
        send_txn(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 34'd0);
        repeat (SC + 1) @(negedge clk);
        chk("hold_res_valid", 64'(res_valid), 64'd1);
        chk("hold_res_sum", 64'(res_sum), 64'h12);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        chk("holdrst_res_valid", 64'(res_valid), 64'd0);
        chk("holdrst_res_sum", 64'(res_sum), 64'd0);
        chk("holdrst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_operand_sequencer.md
Name: csa_operand_sequencer

Overview:
- Upstream feeder and result capture for the 32-bit 4-bit-slice carry-select adder.
- Accepts a byte-serial operand stream over a valid/ready handshake and assembles operand A, then operand B, plus carry-in.
- Holds the assembled operands stable on the adder inputs for a fixed settle window, then registers sum/cout.
- Presents the result on a valid/ready output handshake.

Parameters:
- BYTE_W, 8, input byte width; fixed at 8, since operands are 4 bytes of 32 bits.
- SETTLE_CYCLES, 1, edges the adder inputs are held before sum/cout capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data/in_cin valid.
- in_ready  output  1  sequencer accepts a byte this cycle.
- in_data  input  8  operand byte, little-endian within each operand.
- in_cin  input  1  carry-in; sampled only with the final byte of B.
- add_a  output  32  operand A to the adder.
- add_b  output  32  operand B to the adder.
- add_cin  output  1  carry-in to the adder.
- add_sum  input  32  sum from the adder.
- add_cout  input  1  carry-out from the adder.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  32  registered sum.
- res_cout  output  1  registered carry-out.
- busy  output  1  high in any state other than LOAD_A with byte count 0.

Behaviour:
- Reset: synchronous, active-low; sampled on the rising edge of clk only.
  - Reset values: state=LOAD_A, byte_cnt=0, settle_cnt=0, add_a=0, add_b=0, add_cin=0, res_sum=0, res_cout=0, res_valid=0, busy=0.
  - in_ready is 1 in the first cycle after reset release.
- Byte transfer: a byte transfers on any edge where in_valid && in_ready.
- State LOAD_A:
  - in_ready=1.
  - On each transfer, in_data is written into add_a[8*byte_cnt+7 : 8*byte_cnt] and byte_cnt increments.
  - On the 4th transfer (byte_cnt==3): byte_cnt -> 0, next state LOAD_B.
- State LOAD_B:
  - in_ready=1; same byte placement into add_b.
  - On the 4th transfer, add_cin <= in_cin, settle_cnt <= SETTLE_CYCLES-1, next state SETTLE.
- State SETTLE:
  - in_ready=0; add_a/add_b/add_cin are held constant.
  - Each edge decrements settle_cnt.
  - On the edge where settle_cnt==0: res_sum <= add_sum, res_cout <= add_cout, res_valid <= 1, next state HOLD.
- Latency: res_valid rises exactly SETTLE_CYCLES edges after the edge that accepted the last byte of B.
- State HOLD:
  - in_ready=0; res_* outputs are stable while res_valid && !res_ready.
  - On res_valid && res_ready: res_valid <= 0, next state LOAD_A.
  - in_ready reasserts the following cycle; there is no same-cycle bypass.
- Operand registers add_a/add_b keep their last values until overwritten byte-by-byte in the next transaction. Partially loaded operands are visible on the adder inputs; only the settled value is captured.
- Bubbles: in_valid low in LOAD_A/LOAD_B stalls with no state change, and bytes may arrive with arbitrary gaps.
- Ignored input: in_valid while in_ready=0 is ignored; no byte is consumed.
- Reset mid-operation (any state): the partial transaction is discarded, all outputs return to reset values, and an in-flight res_valid drops without a handshake.
- Throughput: minimum 8 + SETTLE_CYCLES + 1 cycles per add with res_ready held high.
- Arithmetic: performed entirely by the external adder. The sequencer never modifies sum; res_cout is the 33rd bit.

Optional Feature:
- Macro: CSA_SEQ_OVERFLOW_EN.
- When defined:
  - Adds output res_ovf, 1 bit, reset 0.
  - Captured alongside res_sum as the two's-complement signed overflow: (add_a[31]==add_b[31]) && (add_sum[31]!=add_a[31]).
  - Held and cleared under exactly the same rules as res_sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Byte order: A bytes 0x78,0x56,0x34,0x12 and B bytes 0x00,0x00,0x00,0x00, cin=0 -> add_a=0x12345678 in SETTLE; res_sum=0x12345678, res_cout=0.
- Carry out: A=0x00000001, B=0xFFFFFFFF, cin=0 -> res_sum=0x00000000, res_cout=1. Also A=0, B=0xFFFFFFFF, cin=1 -> res_sum=0, res_cout=1.
- Latency and backpressure: SETTLE_CYCLES=3, res_ready held low for 5 cycles after res_valid.
  - res_valid rises 3 edges after the last B byte.
  - res_sum stays stable and in_ready=0 throughout.
  - One cycle after the res_ready handshake, in_ready=1.
- Input gaps: in_valid toggled 1/0 on every byte of both operands -> same result as a back-to-back load; no byte is lost or duplicated. in_valid held high during SETTLE/HOLD consumes nothing.
- Reset mid-load: drive rst_n=0 for one edge after 2 bytes of B, then load a full fresh A=5, B=7, cin=0 -> res_sum=0x0000000C; no stale bytes.
- With CSA_SEQ_OVERFLOW_EN: A=0x7FFFFFFF, B=0x00000001 -> res_sum=0x80000000, res_ovf=1, res_cout=0. A=0xFFFFFFFF, B=0x00000001 -> res_ovf=0, res_cout=1.
